// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline stage: head + skid register under valid/ready, with flush,
// sticky halt capture, writeback-data select and a retired-instruction counter.
module mem_wb_skid #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PC_INC = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_halt,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [1:0]        in_wb_sel,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_ram,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] out_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  typedef struct packed {
    logic              halt;
    logic              reg_write;
    logic [REG_AW-1:0] dest;
    logic [1:0]        wb_sel;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] ram;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
  } entry_t;

  entry_t            w_in;
  entry_t            r_head;
  entry_t            r_skid;
  logic              r_head_v;
  logic              r_skid_v;
  logic              r_halt_seen;
  logic              r_halted;
  logic [CNT_W-1:0]  r_retired;
  logic              w_accept;
  logic              w_pop;
  logic [DATA_W-1:0] w_wb_data;

  always_comb begin
    w_in.halt      = in_halt;
    w_in.reg_write = in_reg_write;
    w_in.dest      = in_dest;
    w_in.wb_sel    = in_wb_sel;
    w_in.alu       = in_alu;
    w_in.ram       = in_ram;
    w_in.pc        = in_pc;
    w_in.imm       = in_imm;
  end

  // Readiness depends on registered state only, so no combinational path in->out.
  assign in_ready = ~r_skid_v & ~r_halt_seen & ~r_halted;
  assign w_accept = in_valid & in_ready & ~flush;
  assign w_pop    = r_head_v & out_ready & ~flush;

  always_comb begin
    w_wb_data = r_head.alu;
    case (r_head.wb_sel)
      2'b00:   w_wb_data = r_head.alu;
      2'b01:   w_wb_data = r_head.ram;
      2'b10:   w_wb_data = r_head.pc + DATA_W'(PC_INC);
      default: w_wb_data = r_head.imm;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head      <= '0;
      r_skid      <= '0;
      r_head_v    <= 1'b0;
      r_skid_v    <= 1'b0;
      r_halt_seen <= 1'b0;
      r_halted    <= 1'b0;
      r_retired   <= '0;
    end else if (flush) begin
      // halted and retired survive an interrupt flush
      r_head_v    <= 1'b0;
      r_skid_v    <= 1'b0;
      r_halt_seen <= 1'b0;
    end else begin
      if (w_accept && in_halt) begin
        r_halt_seen <= 1'b1;
      end
      if (w_pop) begin
        r_retired <= r_retired + CNT_W'(1);
        if (r_head.halt) begin
          r_halted <= 1'b1;
        end
      end
      if (!r_head_v) begin
        if (w_accept) begin
          r_head   <= w_in;
          r_head_v <= 1'b1;
        end
      end else if (w_pop) begin
        if (r_skid_v) begin
          r_head   <= r_skid;
          r_skid_v <= 1'b0;
        end else if (w_accept) begin
          r_head <= w_in;
        end else begin
          r_head_v <= 1'b0;
        end
      end else if (!r_skid_v && w_accept) begin
        r_skid   <= w_in;
        r_skid_v <= 1'b1;
      end
    end
  end

  assign out_valid = r_head_v;
  assign wb_we     = w_pop & r_head.reg_write;
  assign wb_dest   = r_head.dest;
  assign wb_data   = w_wb_data;
  assign out_pc    = r_head.pc;
  assign halted    = r_halted;
  assign retired   = r_retired;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Randomised and directed bench for mem_wb_skid; a queue of expected retirements
// is filled by the driver and drained by a negedge monitor.
module tb_mem_wb_skid;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_halt = 1'b0;
  logic          in_reg_write = 1'b0;
  logic [AW-1:0] in_dest = '0;
  logic [1:0]    in_wb_sel = '0;
  logic [DW-1:0] in_alu = '0, in_ram = '0, in_pc = '0, in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          wb_we;
  logic [AW-1:0] wb_dest;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] out_pc;
  logic          halted;
  logic [CW-1:0] retired;

  mem_wb_skid #(.DATA_W(DW), .REG_AW(AW), .PC_INC(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_halt(in_halt),
    .in_reg_write(in_reg_write), .in_dest(in_dest), .in_wb_sel(in_wb_sel),
    .in_alu(in_alu), .in_ram(in_ram), .in_pc(in_pc), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .wb_we(wb_we),
    .wb_dest(wb_dest), .wb_data(wb_data), .out_pc(out_pc),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            halt;
    bit            rw;
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
    logic [DW-1:0] pc;
  } exp_t;

  exp_t q[$];       // entries held by the stage, oldest first
  exp_t pend;       // accepted this cycle, held from next cycle on
  bit   pend_v = 0;
  bit   m_hs = 0;
  bit   m_halted = 0;
  int   m_ret = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] ref_data(input logic [1:0] sel, input logic [DW-1:0] a,
                                             input logic [DW-1:0] r, input logic [DW-1:0] p,
                                             input logic [DW-1:0] i);
    longint unsigned lnk;
    lnk = (longint'(p) + 1) % (64'd1 << DW);
    case (sel)
      2'd0:    return a;
      2'd1:    return r;
      2'd2:    return lnk[DW-1:0];
      default: return i;
    endcase
  endfunction

  // Monitor: compares the visible head against the oldest expected entry.
  always @(negedge clk) begin
    bit pop;
    bit rdy;
    if (rst) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_wb_we", wb_we, 0);
      check("rst_wb_dest", wb_dest, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_out_pc", out_pc, 0);
      check("rst_halted", halted, 0);
      check("rst_retired", retired, 0);
      q.delete();
      m_hs = 0;
      m_halted = 0;
      m_ret = 0;
      pend_v = 0;
    end else begin
      rdy = (q.size() < 2) && !m_hs && !m_halted;
      pop = (q.size() > 0) && out_ready && !flush;
      check("in_ready", in_ready, rdy);
      check("out_valid", out_valid, q.size() > 0);
      check("halted", halted, m_halted);
      check("retired", retired, m_ret);
      check("wb_we", wb_we, pop && q[0].rw);
      if (q.size() > 0) begin
        check("wb_dest", wb_dest, q[0].dest);
        check("wb_data", wb_data, q[0].data);
        check("out_pc", out_pc, q[0].pc);
      end
      if (flush) begin
        q.delete();
        m_hs = 0;
      end else if (pop) begin
        if (q[0].halt) m_halted = 1;
        m_ret = (m_ret + 1) % (1 << CW);
        void'(q.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input bit h, input bit rw, input logic [AW-1:0] d,
                       input logic [1:0] sel, input logic [DW-1:0] a, input logic [DW-1:0] r,
                       input logic [DW-1:0] p, input logic [DW-1:0] i, input bit ordy,
                       input bit fl);
    bit rdy;
    @(posedge clk);
    #1;
    if (pend_v) begin
      q.push_back(pend);
      if (pend.halt) m_hs = 1;
      pend_v = 0;
    end
    rdy = (q.size() < 2) && !m_hs && !m_halted;
    in_valid = v; in_halt = h; in_reg_write = rw; in_dest = d; in_wb_sel = sel;
    in_alu = a; in_ram = r; in_pc = p; in_imm = i; out_ready = ordy; flush = fl;
    if (v && rdy && !fl) begin
      pend = '{halt: h, rw: rw, dest: d, data: ref_data(sel, a, r, p, i), pc: p};
      pend_v = 1;
    end
  endtask

  task automatic idle(input bit ordy);
    drive(0, 0, 0, '0, 2'd0, '0, '0, '0, '0, ordy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    if (pend_v) begin
      q.push_back(pend);
      pend_v = 0;
    end
    in_valid = 0; flush = 0; out_ready = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Streaming
    for (int k = 0; k < 4; k++)
      drive(1, 0, 1, AW'(k + 1), 2'd0, DW'(32'h10 + k), '0, DW'(k * 4), '0, 1, 0);
    repeat (3) idle(1);

    // Backpressure then drain
    for (int k = 0; k < 4; k++)
      drive(1, 0, 1, AW'(k + 8), 2'd0, DW'(32'h20 + k), '0, DW'(k), '0, 0, 0);
    repeat (4) idle(1);

    // Writeback select, including PC wrap
    for (int k = 0; k < 4; k++)
      drive(1, 0, 1, AW'(k), 2'(k), 32'hA, 32'hB, 32'hFFFF_FFFF, 32'hC, 1, 0);
    repeat (3) idle(1);

    // Flush with in_valid and out_ready
    drive(1, 0, 1, 5'd3, 2'd0, 32'h31, '0, '0, '0, 0, 0);
    drive(1, 0, 1, 5'd4, 2'd0, 32'h32, '0, '0, '0, 0, 0);
    drive(1, 0, 1, 5'd5, 2'd0, 32'h33, '0, '0, '0, 1, 1);
    repeat (2) idle(1);

    // Halt: A, H, then C is refused
    drive(1, 0, 1, 5'd1, 2'd0, 32'hAA, '0, 32'h100, '0, 1, 0);
    drive(1, 1, 0, 5'd2, 2'd0, 32'hBB, '0, 32'h101, '0, 1, 0);
    repeat (5) drive(1, 0, 1, 5'd3, 2'd0, 32'hCC, '0, 32'h102, '0, 1, 0);
    drive(1, 0, 1, 5'd3, 2'd0, 32'hCC, '0, 32'h102, '0, 1, 1);
    repeat (3) drive(1, 0, 1, 5'd3, 2'd0, 32'hCC, '0, 32'h102, '0, 1, 0);
    do_reset();

    // Counter wrap over 9 retirements
    for (int k = 0; k < 9; k++)
      drive(1, 0, k[0], AW'(k), 2'd3, '0, '0, DW'(k), DW'(k + 7), 1, 0);
    repeat (3) idle(1);

    // Reset with both slots occupied
    drive(1, 0, 1, 5'd6, 2'd1, '0, 32'h61, '0, '0, 0, 0);
    drive(1, 0, 1, 5'd7, 2'd1, '0, 32'h62, '0, '0, 0, 0);
    do_reset();
    idle(1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (m_halted && ($urandom % 8 == 0)) begin
        do_reset();
      end else begin
        drive($urandom % 3 != 0, $urandom % 40 == 0, 1'($urandom), AW'($urandom),
              2'($urandom), $urandom, $urandom, $urandom, $urandom,
              $urandom % 3 != 0, $urandom % 14 == 0);
      end
    end
    repeat (4) idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_wb_skid.md
# mem_wb_skid

Parametrised MEM/WB pipeline stage that replaces the fixed single register between memory access and register writeback. It holds up to two in-flight instructions in a head register plus skid register, under a valid/ready handshake, so memory-side stalls never drop data. It also provides:
- a synchronous flush for interrupts;
- halt capture that stays set once reached;
- a registered writeback-data select;
- a retired-instruction counter.

## Interface
Parameters:
- DATA_W, 32, width of ALU/RAM/PC/IMM/writeback data
- REG_AW, 5, register-file address width
- PC_INC, 1, increment added to PC for link writeback (word-addressed PC)
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of all held entries (interrupt)
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  stage accepts an entry this cycle
- in_halt  in  1  entry is a halt instruction
- in_reg_write  in  1  entry writes the register file
- in_dest  in  REG_AW  destination register
- in_wb_sel  in  2  00 ALU, 01 RAM, 10 PC+PC_INC, 11 IMM
- in_alu, in_ram, in_pc, in_imm  in  DATA_W each  candidate writeback operands
- out_valid  out  1  head entry valid
- out_ready  in  1  writeback consumes the head this cycle
- wb_we  out  1  register-file write strobe
- wb_dest  out  REG_AW  head destination
- wb_data  out  DATA_W  selected writeback value of head
- out_pc  out  DATA_W  head PC, for interrupt EPC capture
- halted  out  1  a halt has retired
- retired  out  CNT_W  count of retired entries

## Operation
Handshake terms:
- accept = in_valid & in_ready & ~flush
- pop = out_valid & out_ready & ~flush

Readiness:
- in_ready = ~skid_v & ~halt_seen & ~halted.
- in_ready is combinational from registers only; it never depends on in_valid or out_ready.

Entry movement, per cycle, first matching rule applies:
- flush: head_v and skid_v go to 0 and halt_seen goes to 0. halted and retired are unchanged. Nothing is accepted or popped.
- head empty: accept loads head.
- head valid, pop, skid valid: head gets skid. skid_v goes to 0; no accept is possible because in_ready is 0.
- head valid, pop, skid empty: accept loads head; otherwise head_v goes to 0.
- head valid, no pop, skid empty: accept loads skid.

Entry contents:
- Each held entry stores halt, reg_write, dest, wb_sel, alu, ram, pc and imm.
- wb_data is a mux over the head entry fields selected by wb_sel. Case 10 gives pc + PC_INC, truncated to DATA_W, so it wraps modulo 2^DATA_W.
- wb_we = pop & head.reg_write.
- wb_dest and out_pc always reflect the head, even when invalid.

Halt:
- Accepting an entry with in_halt=1 sets halt_seen. Entries already held keep draining.
- Popping a head with halt=1 sets halted. halted is cleared only by rst; flush does not clear it.
- The halt entry's own reg_write is honoured.

Counter:
- retired increments by 1 on every pop and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset value of every register and output is 0: head_v, skid_v, halt_seen, halted, retired, all stored fields, out_valid, wb_we, wb_dest, wb_data, out_pc. in_ready is 1 while rst is asserted and afterwards.
- Reset mid-operation discards both entries immediately, asynchronously.
- Latency: an entry accepted into an empty head appears on out_valid the next cycle.
- Throughput: one entry per cycle while out_ready=1.
- Backpressure: with out_ready held at 0, the stage accepts at most 2 entries, then in_ready drops to 0 on the cycle after the second accept.
- in_ready returns to 1 on the cycle after the first pop of a full stage.
- Flush and in_valid in the same cycle: the input is dropped. The next cycle has out_valid=0 and in_ready=1, unless halted=1.
- Flush and out_ready in the same cycle: no pop, wb_we=0, retired unchanged.
- After halted=1: in_ready=0 permanently until rst; out_valid=0 once drained.

## Test plan
- Streaming: feed 4 ALU entries (alu=0x10..0x13, dest=1..4, reg_write=1) with out_ready=1 → wb_we high for 4 consecutive cycles starting 1 cycle after the first accept, wb_data 0x10..0x13, retired=4.
- Backpressure: out_ready=0 with continuous in_valid → exactly 2 accepts and in_ready=0 from the following cycle. Then out_ready=1 → both entries retire in order, with no loss or duplication.
- Writeback select: one entry per wb_sel value with alu=0xA, ram=0xB, pc=0xFFFFFFFF, imm=0xC → wb_data 0xA, 0xB, 0x00000000 (PC wrap), 0xC.
- Flush: 2 entries held, assert flush together with in_valid and out_ready → next cycle out_valid=0, in_ready=1, retired unchanged, no wb_we.
- Halt: send A, halt H (reg_write=0), then C → C is never accepted. A then H retire, halted=1 on the cycle after H pops, and in_ready stays 0. A subsequent flush leaves halted=1. rst clears halted and retired.
- Counter wrap with CNT_W=3: retire 9 entries → retired reads 1.
